lzc_norm_pipe: RTL

//  Parametrised, pipelined normaliser for the FP datapath: counts leading zeros of a

---
 rtl/lzc_norm_pkg.sv | 29 ++
 rtl/lzc_norm_pipe_lzc_tree.sv | 46 ++++
 rtl/lzc_norm_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lzc_norm_pkg.sv
// Shared types and helpers for the leading-zero normaliser pipeline.
package lzc_norm_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_EXP_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_CNT_W = clog2(DEF_WIDTH + 1);

    // Biased exponent 0 is reserved for zero and denormal results
    localparam logic [63:0] EXP_ZERO = '0;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] mant;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_CNT_W-1:0] lz;
        logic                 zero;
        logic                 uflow;
    } norm_beat_t;

endpackage

// File: rtl/lzc_norm_pipe_lzc_tree.sv
// Combinational log-depth leading-zero counter; all-zero input reports WIDTH.
module lzc_tree
    import lzc_norm_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] lz_o
);

    localparam int LVL = clog2(WIDTH);
    localparam int P   = 1 << LVL;

    logic [P-1:0] pad_s;

    // Padding the LSBs with ones makes an all-zero mantissa count exactly WIDTH
    if (P > WIDTH) begin : g_pad
        assign pad_s = {data_i, {(P - WIDTH){1'b1}}};
    end else begin : g_nopad
        assign pad_s = data_i;
    end

    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        localparam int N  = P >> k;
        localparam int CW = k + 1;
        logic [N-1:0]         z;
        logic [N-1:0][CW-1:0] c;
        if (k == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign z[i] = ~pad_s[P-1-i];
                assign c[i] = 1'b0;
            end
        end else begin : g_node
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign z[i] = g_lvl[k-1].z[2*i] & g_lvl[k-1].z[2*i+1];
                assign c[i] = g_lvl[k-1].z[2*i]
                            ? (CW'(1 << (k - 1)) + CW'(g_lvl[k-1].c[2*i+1]))
                            : CW'(g_lvl[k-1].c[2*i]);
            end
        end
    end

    assign lz_o = g_lvl[LVL].z[0] ? CNT_W'(WIDTH) : CNT_W'(g_lvl[LVL].c[0]);

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage mantissa normaliser with valid/ready on both sides.
// Optional macro LZC_NORM_DENORM_CLAMP_EN: clamp the shift on underflow to build a denormal.
module lzc_norm_pipe
    import lzc_norm_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int EXP_W = DEF_EXP_W,
    localparam int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_mant_i,
    input  logic [EXP_W-1:0] in_exp_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_mant_o,
    output logic [EXP_W-1:0] out_exp_o,
    output logic [CNT_W-1:0] out_lz_o,
    output logic             out_zero_o,
    output logic             out_uflow_o
);

    localparam int EW = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic [CNT_W-1:0] lz;
        logic             zero;
        logic             uflow;
    } beat_t;

    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic             s1_load_s, s2_load_s;
    logic [WIDTH-1:0] s1_mant_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [CNT_W-1:0] s1_lz_q;
    logic [CNT_W-1:0] in_lz_s;
    logic [CNT_W-1:0] shift_s;
    logic signed [EW-1:0] e_s;
    logic             zero_s, uflow_s;
    beat_t            out_q, out_d;

    lzc_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
        .data_i (in_mant_i),
        .lz_o   (in_lz_s)
    );

    // No skid buffer: ready ripples combinationally back from out_ready_i
    assign s2_load_s  = ~out_valid_q | out_ready_i;
    assign s1_load_s  = ~s1_valid_q | s2_load_s;
    assign in_ready_o = s1_load_s;

    // Stage valid flags advance only when the stage is allowed to load
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (s1_load_s) begin
            s1_valid_d = in_valid_i;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Second stage: exponent adjust, underflow detection and the barrel shift
    always_comb begin
        e_s     = $signed(EW'(s1_exp_q)) - $signed(EW'(s1_lz_q));
        zero_s  = (s1_lz_q == CNT_W'(WIDTH));
        uflow_s = ~zero_s & (e_s[EW-1] | (e_s == '0));
        shift_s = s1_lz_q;
`ifdef LZC_NORM_DENORM_CLAMP_EN
        if (uflow_s) begin
            if (s1_exp_q == EXP_W'(EXP_ZERO)) begin
                shift_s = '0;
            end else begin
                shift_s = CNT_W'(s1_exp_q - EXP_W'(1));
            end
        end else begin
            shift_s = s1_lz_q;
        end
`endif
        out_d    = '0;
        out_d.lz = s1_lz_q;
        if (zero_s) begin
            out_d.mant  = '0;
            out_d.exp   = EXP_W'(EXP_ZERO);
            out_d.zero  = 1'b1;
            out_d.uflow = 1'b0;
        end else if (uflow_s) begin
            out_d.mant  = s1_mant_q << shift_s;
            out_d.exp   = EXP_W'(EXP_ZERO);
            out_d.zero  = 1'b0;
            out_d.uflow = 1'b1;
        end else begin
            out_d.mant  = s1_mant_q << shift_s;
            out_d.exp   = e_s[EXP_W-1:0];
            out_d.zero  = 1'b0;
            out_d.uflow = 1'b0;
        end
    end

    // Pipeline registers; data only moves with a valid beat so held outputs stay put
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_mant_q   <= '0;
            s1_exp_q    <= '0;
            s1_lz_q     <= '0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (s1_load_s & in_valid_i) begin
                s1_mant_q <= in_mant_i;
                s1_exp_q  <= in_exp_i;
                s1_lz_q   <= in_lz_s;
            end
            if (s2_load_s & s1_valid_q) begin
                out_q <= out_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_mant_o  = out_q.mant;
    assign out_exp_o   = out_q.exp;
    assign out_lz_o    = out_q.lz;
    assign out_zero_o  = out_q.zero;
    assign out_uflow_o = out_q.uflow;

endmodule
